// File: rtl/hazard_dest_pipe_pkg.sv
// Shared register-address constants and the {dest, wb_en} stage pair.
// The hazard detector and register file import this package as well.
package hazard_dest_pipe_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int STAGE_PAIR_W = REG_ADDR_W + 1;
  localparam int NUM_STAGES   = 3;  // EXE, MEM, WB

  localparam logic [REG_ADDR_W-1:0] BUBBLE_DEST = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
  } stage_pair_t;
endpackage

// File: rtl/hazard_dest_pipe_if.sv
// ID-side inputs, stage destinations and hold/statistics outputs.
// The slave modport belongs to the pipe; the master modport belongs to the ID/hazard side.
interface hazard_dest_pipe_if #(parameter int CNT_W = 16);
  import hazard_dest_pipe_pkg::*;

  logic [REG_ADDR_W-1:0] Dest_ID;
  logic                  WB_EN_ID;
  logic                  Freeze;
  logic                  Flush;
  logic                  Mem_Ready;
  logic [REG_ADDR_W-1:0] Dest_EXE, Dest_MEM, Dest_WB;
  logic                  WB_EN_EXE, WB_EN_MEM, WB_EN_WB;
  logic                  PC_Hold;
  logic                  IFID_Hold;
  logic [CNT_W-1:0]      Stall_Cnt;
  logic [CNT_W-1:0]      Flush_Cnt;

  modport slave (
    input  Dest_ID, WB_EN_ID, Freeze, Flush, Mem_Ready,
    output Dest_EXE, Dest_MEM, Dest_WB, WB_EN_EXE, WB_EN_MEM, WB_EN_WB,
           PC_Hold, IFID_Hold, Stall_Cnt, Flush_Cnt
  );

  modport master (
    output Dest_ID, WB_EN_ID, Freeze, Flush, Mem_Ready,
    input  Dest_EXE, Dest_MEM, Dest_WB, WB_EN_EXE, WB_EN_MEM, WB_EN_WB,
           PC_Hold, IFID_Hold, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/hazard_dest_pipe_stage_reg.sv
// One {dest, wb_en} pipeline stage register with enable and bubble insert.
module hazard_stage_reg
  import hazard_dest_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  bubble,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  wb_en_in,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  wb_en_out
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_out  <= BUBBLE_DEST;
      wb_en_out <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        dest_out  <= BUBBLE_DEST;
        wb_en_out <= 1'b0;
      end else begin
        dest_out  <= dest_in;
        wb_en_out <= wb_en_in;
      end
    end
  end
endmodule

// File: rtl/hazard_dest_pipe.sv
// Tracks in-flight destinations through EXE/MEM/WB, inserts Freeze/Flush
// bubbles, drives PC/IF-ID hold strobes and keeps saturating bubble counters.
module hazard_dest_pipe
  import hazard_dest_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  hazard_dest_pipe_if.slave   bus
);
  logic                                   advance;
  logic                                   kill;
  logic [NUM_STAGES:0][REG_ADDR_W-1:0]    dest_c;
  logic [NUM_STAGES:0]                    wb_c;
  logic [CNT_W-1:0]                       stall_cnt;
  logic [CNT_W-1:0]                       flush_cnt;

  assign advance = bus.Mem_Ready;
  assign kill    = bus.Flush | bus.Freeze;

  // r0 is never a live destination, so its write enable is dropped on entry.
  assign dest_c[0] = bus.Dest_ID;
  assign wb_c[0]   = bus.WB_EN_ID & (bus.Dest_ID != REG_ADDR_W'(0));

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    hazard_stage_reg u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .bubble    ((g == 0) ? kill : 1'b0),
      .dest_in   (dest_c[g]),
      .wb_en_in  (wb_c[g]),
      .dest_out  (dest_c[g+1]),
      .wb_en_out (wb_c[g+1])
    );
  end

  assign bus.Dest_EXE  = dest_c[1];
  assign bus.WB_EN_EXE = wb_c[1];
  assign bus.Dest_MEM  = dest_c[2];
  assign bus.WB_EN_MEM = wb_c[2];
  assign bus.Dest_WB   = dest_c[3];
  assign bus.WB_EN_WB  = wb_c[3];

  // Flush wins: a flushed instruction needs no re-issue, so the PC may move.
  assign bus.PC_Hold   = (bus.Freeze & ~bus.Flush) | ~bus.Mem_Ready;
  assign bus.IFID_Hold = bus.PC_Hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (advance) begin
      if (bus.Flush) begin
        if (~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
      end else if (bus.Freeze) begin
        if (~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.Stall_Cnt = stall_cnt;
  assign bus.Flush_Cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Directed scoreboard bench: a 16-bit-counter DUT and a 2-bit-counter DUT share stimulus.
module tb_hazard_dest_pipe;
  import hazard_dest_pipe_pkg::*;

  typedef struct packed {
    logic [4:0]  de; logic we;
    logic [4:0]  dm; logic wm;
    logic [4:0]  dw; logic ww;
    logic [15:0] s;  logic [15:0] f;
    logic [1:0]  ss; logic [1:0]  sf;
    logic        h;  logic        ih;
  } snap_t;

  typedef struct {
    snap_t snap;
    int    row;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row_no  = 0;

  always #5 clk = ~clk;

  hazard_dest_pipe_if #(.CNT_W(16)) b16 ();
  hazard_dest_pipe_if #(.CNT_W(2))  b2  ();

  hazard_dest_pipe #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(b16));
  hazard_dest_pipe #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(b2));

  task automatic drive(input logic r, input logic [4:0] id, input logic wb,
                       input logic frz, input logic fl, input logic mr);
    rst = r;
    b16.Dest_ID = id; b16.WB_EN_ID = wb; b16.Freeze = frz; b16.Flush = fl; b16.Mem_Ready = mr;
    b2.Dest_ID  = id; b2.WB_EN_ID  = wb; b2.Freeze  = frz; b2.Flush  = fl; b2.Mem_Ready  = mr;
  endtask

  // Drive one cycle's inputs just after the edge and queue what the negedge must show.
  task automatic step(input logic r, input logic [4:0] id, input logic wb,
                      input logic frz, input logic fl, input logic mr,
                      input logic [4:0] de, input logic we, input logic [4:0] dm, input logic wm,
                      input logic [4:0] dw, input logic ww,
                      input int s, input int f, input int ss, input int sf, input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    drive(r, id, wb, frz, fl, mr);
    e.snap = '{de: de, we: we, dm: dm, wm: wm, dw: dw, ww: ww,
               s: 16'(s), f: 16'(f), ss: 2'(ss), sf: 2'(sf), h: h, ih: h};
    e.row = row_no;
    sb.push_back(e);
    row_no++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  e;
      snap_t act;
      e   = sb.pop_front();
      act = {b16.Dest_EXE, b16.WB_EN_EXE, b16.Dest_MEM, b16.WB_EN_MEM,
             b16.Dest_WB, b16.WB_EN_WB, b16.Stall_Cnt, b16.Flush_Cnt,
             b2.Stall_Cnt, b2.Flush_Cnt, b16.PC_Hold, b16.IFID_Hold};
      n_tests++;
      if (act !== e.snap) begin
        n_fail++;
        $display("FAIL row%0d got exe=%0d/%0b mem=%0d/%0b wb=%0d/%0b stall=%0d flush=%0d sstall=%0d sflush=%0d hold=%0b ifid=%0b",
                 e.row, act.de, act.we, act.dm, act.wm, act.dw, act.ww, act.s, act.f, act.ss, act.sf, act.h, act.ih);
        $display("     row%0d want exe=%0d/%0b mem=%0d/%0b wb=%0d/%0b stall=%0d flush=%0d sstall=%0d sflush=%0d hold=%0b ifid=%0b",
                 e.row, e.snap.de, e.snap.we, e.snap.dm, e.snap.wm, e.snap.dw, e.snap.ww,
                 e.snap.s, e.snap.f, e.snap.ss, e.snap.sf, e.snap.h, e.snap.ih);
      end
    end
  end

  initial begin
    drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    //    rst id wb frz fl mr | exe      mem      wb       S  F  s  f  hold
    step(1, 0, 0, 1, 0, 1,    0, 0,    0, 0,    0, 0,    0, 0, 0, 0, 1); // reset, hold follows Freeze
    step(1, 0, 0, 0, 0, 1,    0, 0,    0, 0,    0, 0,    0, 0, 0, 0, 0);
    step(0, 3, 1, 0, 0, 1,    0, 0,    0, 0,    0, 0,    0, 0, 0, 0, 0); // steady issue 3,4,5
    step(0, 4, 1, 0, 0, 1,    3, 1,    0, 0,    0, 0,    0, 0, 0, 0, 0);
    step(0, 5, 1, 0, 0, 1,    4, 1,    3, 1,    0, 0,    0, 0, 0, 0, 0);
    step(0, 7, 1, 1, 0, 1,    5, 1,    4, 1,    3, 1,    0, 0, 0, 0, 1); // freeze x2 on 7
    step(0, 7, 1, 1, 0, 1,    0, 0,    5, 1,    4, 1,    1, 0, 1, 0, 1);
    step(0, 7, 1, 0, 0, 1,    0, 0,    0, 0,    5, 1,    2, 0, 2, 0, 0);
    step(0, 8, 1, 1, 1, 1,    7, 1,    0, 0,    0, 0,    2, 0, 2, 0, 0); // flush beats freeze
    step(0, 4, 1, 0, 0, 1,    0, 0,    7, 1,    0, 0,    2, 1, 2, 1, 0); // fill 4,9,2
    step(0, 9, 1, 0, 0, 1,    4, 1,    0, 0,    7, 1,    2, 1, 2, 1, 0);
    step(0, 2, 1, 0, 0, 1,    9, 1,    4, 1,    0, 0,    2, 1, 2, 1, 0);
    step(0, 6, 1, 1, 1, 0,    2, 1,    9, 1,    4, 1,    2, 1, 2, 1, 1); // mem stall, flush ignored
    step(0, 6, 1, 1, 0, 0,    2, 1,    9, 1,    4, 1,    2, 1, 2, 1, 1);
    step(0, 6, 1, 1, 0, 0,    2, 1,    9, 1,    4, 1,    2, 1, 2, 1, 1);
    step(0, 0, 1, 0, 0, 1,    2, 1,    9, 1,    4, 1,    2, 1, 2, 1, 0); // r0 with wb_en=1
    step(0, 6, 1, 1, 0, 1,    0, 0,    2, 1,    9, 1,    2, 1, 2, 1, 1); // freezes 3..5
    step(0, 6, 1, 1, 0, 1,    0, 0,    0, 0,    2, 1,    3, 1, 3, 1, 1);
    step(0, 6, 1, 1, 0, 1,    0, 0,    0, 0,    0, 0,    4, 1, 3, 1, 1);
    step(0, 6, 1, 0, 0, 1,    0, 0,    0, 0,    0, 0,    5, 1, 3, 1, 0);
    step(1, 6, 1, 0, 0, 1,    0, 0,    0, 0,    0, 0,    0, 0, 0, 0, 0); // async reset mid-cycle
    step(0, 0, 0, 0, 0, 1,    0, 0,    0, 0,    0, 0,    0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
